// File: rtl/cv32e40x_dbg_trace_buffer.sv
// Debug trace buffer: circular capture of retired-instruction debug records with
// trigger/post-trigger stop, then drained to a reader over valid/ready.
module cv32e40x_dbg_trace_buffer #(
   parameter int unsigned DEPTH     = 8,
   parameter int unsigned POST_TRIG = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       arm_i,
   input  logic                       trig_en_i,
   input  logic [6:0]                 trig_opcode_i,
   input  logic                       rec_valid_i,
   input  logic [31:0]                instr_i,
   input  logic                       is_compressed_i,
   input  logic                       rf_we_i,
   input  logic [4:0]                 rf_waddr_i,
   input  logic                       illegal_insn_i,
   output logic                       rd_valid_o,
   input  logic                       rd_ready_i,
   output logic [39:0]                rd_data_o,
   output logic [1:0]                 state_o,
   output logic [$clog2(DEPTH+1)-1:0] count_o,
   output logic [7:0]                 dropped_o
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH+1);
   localparam logic [PW-1:0] PTR_ONE  = PW'(1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      POST  = 2'd2,
      DONE  = 2'd3
   } state_e;

   state_e         state_reg, state_next;
   logic [CW-1:0]  post_cnt_reg, post_cnt_next;
   logic [CW-1:0]  count_reg;
   logic [PW-1:0]  wr_ptr_reg, rd_ptr_reg;
   logic [7:0]     dropped_reg;
   logic [39:0]    mem [DEPTH];

   logic           trig;
   logic           capture;
   logic           pop;
   logic           full;
   logic           empty;
   logic [39:0]    rec_word;

   assign full     = (count_reg == CNT_FULL);
   assign empty    = (count_reg == '0);
   assign trig     = rec_valid_i & (illegal_insn_i | (trig_en_i & (instr_i[6:0] == trig_opcode_i)));
   assign capture  = !arm_i & rec_valid_i & ((state_reg == ARMED) | (state_reg == POST));
   assign pop      = !arm_i & (state_reg == DONE) & !empty & rd_ready_i;
   assign rec_word = {illegal_insn_i, rf_we_i, rf_waddr_i, is_compressed_i, instr_i};

   always_comb begin
      state_next    = state_reg;
      post_cnt_next = post_cnt_reg;
      if (arm_i) begin
         state_next    = ARMED;
         post_cnt_next = '0;
      end else begin
         case (state_reg)
            ARMED: begin
               if (trig) begin
                  if (POST_TRIG == 0) begin
                     state_next = DONE;
                  end else begin
                     state_next    = POST;
                     post_cnt_next = CW'(POST_TRIG);
                  end
               end
            end
            POST: begin
               // Triggers are ignored here; only the post-record countdown matters.
               if (rec_valid_i) begin
                  post_cnt_next = post_cnt_reg - CNT_ONE;
                  if (post_cnt_reg == CNT_ONE) state_next = DONE;
               end
            end
            DONE: begin
               if (empty || (pop && (count_reg == CNT_ONE))) state_next = IDLE;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= IDLE;
         post_cnt_reg <= '0;
      end else begin
         state_reg    <= state_next;
         post_cnt_reg <= post_cnt_next;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg  <= '0;
         rd_ptr_reg  <= '0;
         count_reg   <= '0;
         dropped_reg <= '0;
      end else if (arm_i) begin
         wr_ptr_reg  <= '0;
         rd_ptr_reg  <= '0;
         count_reg   <= '0;
         dropped_reg <= '0;
      end else if (capture) begin
         wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
         // A full buffer loses its oldest record so the pipeline never stalls.
         if (full) begin
            rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            if (dropped_reg != 8'hFF) dropped_reg <= dropped_reg + 8'd1;
         end else begin
            count_reg <= count_reg + CNT_ONE;
         end
      end else if (pop) begin
         rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
         count_reg  <= count_reg - CNT_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (capture) mem[wr_ptr_reg] <= rec_word;
   end

   assign rd_valid_o = (state_reg == DONE) & !empty;
   assign rd_data_o  = rd_valid_o ? mem[rd_ptr_reg] : '0;
   assign state_o    = state_reg;
   assign count_o    = count_reg;
   assign dropped_o  = dropped_reg;

endmodule

// File: tb/tb_cv32e40x_dbg_trace_buffer.sv
// Bench for cv32e40x_dbg_trace_buffer: vector table, directed corner sequences and
// randomized traffic against a queue-based reference model.
module tb_cv32e40x_dbg_trace_buffer;

   localparam int PT = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        arm, trig_en, rec_valid, is_c, rf_we, illegal, rd_ready;
   logic [6:0]  trig_opcode;
   logic [31:0] instr;
   logic [4:0]  rf_waddr;

   logic        rd_valid, rd_valid0;
   logic [39:0] rd_data, rd_data0;
   logic [1:0]  state, state0;
   logic [3:0]  count, count0;
   logic [7:0]  dropped, dropped0;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   cv32e40x_dbg_trace_buffer #(.DEPTH(8), .POST_TRIG(PT)) dut (
      .clk(clk), .rst_n(rst_n), .arm_i(arm), .trig_en_i(trig_en), .trig_opcode_i(trig_opcode),
      .rec_valid_i(rec_valid), .instr_i(instr), .is_compressed_i(is_c), .rf_we_i(rf_we),
      .rf_waddr_i(rf_waddr), .illegal_insn_i(illegal), .rd_valid_o(rd_valid),
      .rd_ready_i(rd_ready), .rd_data_o(rd_data), .state_o(state), .count_o(count),
      .dropped_o(dropped)
   );

   cv32e40x_dbg_trace_buffer #(.DEPTH(8), .POST_TRIG(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .arm_i(arm), .trig_en_i(trig_en), .trig_opcode_i(trig_opcode),
      .rec_valid_i(rec_valid), .instr_i(instr), .is_compressed_i(is_c), .rf_we_i(rf_we),
      .rf_waddr_i(rf_waddr), .illegal_insn_i(illegal), .rd_valid_o(rd_valid0),
      .rd_ready_i(rd_ready), .rd_data_o(rd_data0), .state_o(state0), .count_o(count0),
      .dropped_o(dropped0)
   );

   // Reference model: a plain queue of records plus a phase number.
   logic [39:0] mq[$];
   int          m_state = 0;
   int          m_post = 0;
   int          m_dropped = 0;

   task automatic chk(input string nm, input logic [39:0] act, input logic [39:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_update();
      logic        t;
      logic [39:0] w;
      t = rec_valid && (illegal || (trig_en && (instr[6:0] == trig_opcode)));
      w = {illegal, rf_we, rf_waddr, is_c, instr};
      if (arm) begin
         mq.delete();
         m_state   = 1;
         m_dropped = 0;
      end else if ((m_state == 1 || m_state == 2) && rec_valid) begin
         mq.push_back(w);
         if (mq.size() > 8) begin
            void'(mq.pop_front());
            if (m_dropped < 255) m_dropped++;
         end
         if (m_state == 1 && t) begin
            if (PT == 0) m_state = 3;
            else begin m_state = 2; m_post = PT; end
         end else if (m_state == 2) begin
            m_post--;
            if (m_post == 0) m_state = 3;
         end
      end else if (m_state == 3 && mq.size() > 0 && rd_ready) begin
         void'(mq.pop_front());
         if (mq.size() == 0) m_state = 0;
      end
   endtask

   task automatic check_model();
      logic        ev;
      logic [39:0] ed;
      ev = (m_state == 3) && (mq.size() > 0);
      ed = ev ? mq[0] : 40'd0;
      chk("m_state", 40'(state), 40'(m_state));
      chk("m_count", 40'(count), 40'(mq.size()));
      chk("m_dropped", 40'(dropped), 40'(m_dropped));
      chk("m_rd_valid", 40'(rd_valid), 40'(ev));
      chk("m_rd_data", rd_data, ed);
   endtask

   task automatic step();
      model_update();
      @(posedge clk);
      #1;
      check_model();
   endtask

   task automatic rec(input logic [31:0] ins);
      rec_valid = 1'b1;
      instr     = ins;
      step();
      rec_valid = 1'b0;
   endtask

   task automatic do_arm();
      arm = 1'b1;
      step();
      arm = 1'b0;
   endtask

   typedef struct {
      int          arm;
      int          rv;
      logic [31:0] ins;
      int          rdy;
      int          st;
      int          cnt;
      int          drp;
      int          vld;
      logic [31:0] dat;
   } vec_t;

   vec_t        vt[17];
   logic [31:0] rd_seq[7];
   logic [31:0] exp_seq[8];
   logic [39:0] held;

   initial begin
      rst_n = 1'b0;
      {arm, trig_en, rec_valid, is_c, rf_we, illegal, rd_ready} = '0;
      trig_opcode = 7'h73; instr = '0; rf_waddr = '0;

      // Reset with inputs toggling
      for (int i = 0; i < 4; i++) begin
         {arm, trig_en, rec_valid, illegal, rd_ready} = 5'($urandom);
         instr = $urandom;
         @(posedge clk); #1;
         chk("rst_state", 40'(state), 40'd0);
         chk("rst_count", 40'(count), 40'd0);
         chk("rst_dropped", 40'(dropped), 40'd0);
         chk("rst_rd_valid", 40'(rd_valid), 40'd0);
         chk("rst_rd_data", rd_data, 40'd0);
         chk("rst0_state", 40'(state0), 40'd0);
      end
      {arm, trig_en, rec_valid, is_c, rf_we, illegal, rd_ready} = '0;
      instr = '0;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Vector table: capture around opcode trigger, then full drain
      rd_seq = '{32'd2, 32'd3, 32'h00100073, 32'd5, 32'd6, 32'd7, 32'd8};
      vt[0] = '{arm:1, rv:0, ins:0, rdy:0, st:1, cnt:0, drp:0, vld:0, dat:0};
      for (int i = 1; i <= 3; i++)
         vt[i] = '{arm:0, rv:1, ins:32'(i), rdy:0, st:1, cnt:i, drp:0, vld:0, dat:0};
      vt[4] = '{arm:0, rv:1, ins:32'h00100073, rdy:0, st:2, cnt:4, drp:0, vld:0, dat:0};
      for (int k = 0; k < 3; k++)
         vt[5+k] = '{arm:0, rv:1, ins:32'(5+k), rdy:0, st:2, cnt:5+k, drp:0, vld:0, dat:0};
      vt[8] = '{arm:0, rv:1, ins:32'd8, rdy:0, st:3, cnt:8, drp:0, vld:1, dat:32'd1};
      for (int k = 0; k < 7; k++)
         vt[9+k] = '{arm:0, rv:0, ins:0, rdy:1, st:3, cnt:7-k, drp:0, vld:1, dat:rd_seq[k]};
      vt[16] = '{arm:0, rv:0, ins:0, rdy:1, st:0, cnt:0, drp:0, vld:0, dat:0};

      trig_en = 1'b1;
      for (int i = 0; i < 17; i++) begin
         arm = (vt[i].arm != 0); rec_valid = (vt[i].rv != 0);
         instr = vt[i].ins; rd_ready = (vt[i].rdy != 0);
         step();
         chk("tbl_state", 40'(state), 40'(vt[i].st));
         chk("tbl_count", 40'(count), 40'(vt[i].cnt));
         chk("tbl_dropped", 40'(dropped), 40'(vt[i].drp));
         chk("tbl_rd_valid", 40'(rd_valid), 40'(vt[i].vld));
         chk("tbl_rd_data", rd_data, 40'(vt[i].dat));
      end
      {arm, rec_valid, rd_ready} = '0;

      // Overflow before and after trigger
      do_arm();
      for (int i = 1; i <= 12; i++) rec(32'(i));
      chk("ovf_count", 40'(count), 40'd8);
      chk("ovf_dropped", 40'(dropped), 40'd4);
      rec(32'hABC00073);
      for (int i = 13; i <= 16; i++) rec(32'(i));
      chk("ovf_dropped_post", 40'(dropped), 40'd9);
      chk("ovf_state", 40'(state), 40'd3);
      exp_seq = '{32'd10, 32'd11, 32'd12, 32'hABC00073, 32'd13, 32'd14, 32'd15, 32'd16};
      rd_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         chk("ovf_read", rd_data, 40'(exp_seq[k]));
         step();
      end
      chk("ovf_idle", 40'(state), 40'd0);
      rd_ready = 1'b0;

      // Illegal instruction trigger with POST_TRIG=0 instance
      trig_en = 1'b0;
      do_arm();
      illegal = 1'b1;
      rec(32'h00000055);
      illegal = 1'b0;
      chk("ill_state0", 40'(state0), 40'd3);
      chk("ill_count0", 40'(count0), 40'd1);
      chk("ill_valid0", 40'(rd_valid0), 40'd1);
      chk("ill_bit39", 40'(rd_data0[39]), 40'd1);

      // Hold off reader in DONE while records keep arriving
      for (int i = 0; i < 4; i++) rec(32'(32'h100 + i));
      chk("hold_state", 40'(state), 40'd3);
      held = rd_data;
      rec_valid = 1'b1; instr = 32'h00000073; rd_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("hold_valid", 40'(rd_valid), 40'd1);
         chk("hold_data", rd_data, held);
         chk("hold_count", 40'(count), 40'd5);
      end

      // Arm in DONE with a record present
      arm = 1'b1; instr = 32'h99;
      step();
      arm = 1'b0; rec_valid = 1'b0;
      chk("armdone_state", 40'(state), 40'd1);
      chk("armdone_count", 40'(count), 40'd0);
      chk("armdone_dropped", 40'(dropped), 40'd0);

      // Arm in POST with a record present, dropped non-zero beforehand
      for (int i = 1; i <= 10; i++) rec(32'(i));
      trig_en = 1'b1;
      rec(32'h00000073);
      chk("armpost_pre", 40'(state), 40'd2);
      arm = 1'b1; rec_valid = 1'b1; instr = 32'h77;
      step();
      arm = 1'b0; rec_valid = 1'b0;
      chk("armpost_state", 40'(state), 40'd1);
      chk("armpost_count", 40'(count), 40'd0);
      chk("armpost_dropped", 40'(dropped), 40'd0);

      // Dropped counter saturation
      trig_en = 1'b0;
      do_arm();
      for (int i = 0; i < 300; i++) rec(32'h11);
      chk("sat_dropped", 40'(dropped), 40'd255);
      chk("sat_count", 40'(count), 40'd8);

      // Randomized traffic against the model
      for (int n = 0; n < 3000; n++) begin
         arm       = ($urandom_range(0, 99) < 3);
         rec_valid = $urandom_range(0, 1) == 1;
         trig_en   = $urandom_range(0, 1) == 1;
         instr     = $urandom;
         if ($urandom_range(0, 7) == 0) instr[6:0] = 7'h73;
         illegal   = ($urandom_range(0, 31) == 0);
         is_c      = $urandom_range(0, 1) == 1;
         rf_we     = $urandom_range(0, 1) == 1;
         rf_waddr  = 5'($urandom);
         rd_ready  = $urandom_range(0, 1) == 1;
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
